formula_sched: RTL
==================

FORMULA_SCHED -- requirements
Module: formula_sched

Interface
REQ-001 Parameter LEN, default 8, operand width of the shared formula pipeline.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter LAT, default 5, fixed pipeline latency from fm_vld to fm_out_vld.
REQ-004 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  grant enable; low stops new grants.
REQ-007 req_vld  input  NREQ  per-requester request valid.
REQ-008 req_rdy  output  NREQ  per-requester accept; one-hot or zero.
REQ-009 req_a, req_b, req_c, req_d  input  NREQ*LEN each  packed signed operands; requester i occupies bits [i*LEN +: LEN].
REQ-010 fm_a, fm_b, fm_c, fm_d  output  LEN each  registered operands to the pipeline.
REQ-011 fm_vld  output  1  registered issue strobe to the pipeline.
REQ-012 fm_res  input  3*LEN  pipeline result; fm_ovf  input  1  overflow; fm_out_vld  input  1  result valid.
REQ-013 rsp_vld  output  NREQ  one-hot response strobe; rsp_res  output  3*LEN; rsp_ovf  output  1.
REQ-014 busy  output  1  high when any issued request is outstanding.
REQ-015 tag_err  output  1  sticky tracking-error flag.

Function
REQ-016 Arbitration SHALL be round-robin: search starts at pointer ptr and proceeds upward with wrap; the first i with req_vld[i] gets req_rdy[i]=1, only when en=1.
REQ-017 req_rdy SHALL be combinational from req_vld, ptr and en; a request is accepted in a cycle when req_vld[i] and req_rdy[i] are both high.
REQ-018 On acceptance of requester i, ptr SHALL become (i+1) mod NREQ; with no acceptance ptr SHALL hold.
REQ-019 The accepted operands SHALL appear on fm_a..fm_d with fm_vld=1 in the cycle after acceptance; fm_vld SHALL be 0 otherwise and fm_a..fm_d SHALL hold their last values.
REQ-020 At most one request SHALL be accepted per cycle; back-to-back acceptance every cycle SHALL be supported.
REQ-021 A tag shift register of LAT stages SHALL carry {valid, requester index} of each issue and advance every cycle.
REQ-022 On fm_out_vld=1 with a valid tag at the last stage, rsp_vld SHALL assert the bit of that index combinationally in that cycle; rsp_res=fm_res and rsp_ovf=fm_ovf pass through unregistered.
REQ-023 Requesters SHALL always accept responses; there is no response backpressure.
REQ-024 The outstanding counter (0..LAT) SHALL increment on issue and decrement on fm_out_vld; when both occur in one cycle it SHALL hold.
REQ-025 busy SHALL equal (counter != 0) or fm_vld.
REQ-026 State machine: IDLE (counter 0), RUN (en=1, counter>0), DRAIN (en=0, counter>0); IDLE->RUN on issue, RUN->DRAIN when en falls, DRAIN->RUN when en rises, RUN/DRAIN->IDLE when the counter reaches 0.
REQ-027 tag_err SHALL set and stay set when fm_out_vld=1 with an invalid last-stage tag or counter 0, or when the last-stage tag is valid and fm_out_vld=0; rsp_vld SHALL then be 0.
REQ-028 Deasserting en mid-operation SHALL NOT cancel outstanding results.

Reset
REQ-029 Reset SHALL clear ptr to 0, counter, fm_vld, rsp-tag valid bits, tag_err, fm_a..fm_d and the state to IDLE; req_rdy and rsp_vld SHALL be 0 during reset.
REQ-030 Reset mid-operation SHALL discard all in-flight tags; results arriving later SHALL NOT raise tag_err until a new issue has occurred.

Configuration
REQ-031 With FORMULA_SCHED_STATS_EN defined, the block SHALL add outputs grant_cnt (NREQ*16, a saturating per-requester acceptance count) and ovf_cnt (16, a saturating count of responses with rsp_ovf=1), both cleared by reset.
REQ-032 Without FORMULA_SCHED_STATS_EN, those ports and counters SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-033 Requester 2 alone, a=5 b=2 c=1 d=1, at cycle T -> fm_vld at T+1, rsp_vld=4'b0100 at T+1+LAT with rsp_res=4 and rsp_ovf=0.
REQ-034 All four requesters held valid from cycle T with ptr=0 -> grants 0,1,2,3,0 at T..T+4; responses return in the same order, each at LAT+1 cycles after its grant.
REQ-035 Requester 1 with a=127 b=-128 -> rsp_vld[1]=1 with rsp_ovf=1; the stats build shows ovf_cnt=1.
REQ-036 en dropped with 3 requests outstanding -> no req_rdy, state DRAIN, all 3 responses delivered, then IDLE with busy=0.
REQ-037 rst pulsed with 2 requests in flight -> ptr=0, busy=0, no rsp_vld and tag_err=0 for the stale results.
REQ-038 fm_out_vld forced high with no issue -> tag_err=1 and persists until reset; rsp_vld stays 0.

Source files
------------

// File: rtl/formula_sched.sv
// formula_sched: round-robin scheduler in front of a shared fixed-latency formula pipeline.
//
// Requesters present four signed operands each. One requester is granted per cycle.
// The granted operands are registered onto the pipeline inputs. A tag shift register
// tracks the requester of each issue, so each result is routed back to its requester.
//
// Optional feature: define FORMULA_SCHED_STATS_EN to add the grant_cnt and ovf_cnt
// statistics outputs. The default build omits them.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  grant enable
//   req_vld / req_rdy   per-requester request handshake (req_rdy one-hot or zero)
//   req_a..req_d        packed operands, requester i at [i*LEN +: LEN]
//   fm_a..fm_d, fm_vld  registered issue to the pipeline
//   fm_res, fm_ovf,
//   fm_out_vld          pipeline result, LAT cycles after fm_vld
//   rsp_vld, rsp_res,
//   rsp_ovf             one-hot response strobe with pass-through result
//   busy                outstanding work present
//   tag_err             sticky result/tag tracking error
//   grant_cnt, ovf_cnt  saturating statistics (FORMULA_SCHED_STATS_EN only)

module formula_sched #(
   parameter int unsigned LEN  = 8,
   parameter int unsigned NREQ = 4,
   parameter int unsigned LAT  = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [NREQ-1:0]     req_vld,
   output logic [NREQ-1:0]     req_rdy,
   input  logic [NREQ*LEN-1:0] req_a,
   input  logic [NREQ*LEN-1:0] req_b,
   input  logic [NREQ*LEN-1:0] req_c,
   input  logic [NREQ*LEN-1:0] req_d,
   output logic [LEN-1:0]      fm_a,
   output logic [LEN-1:0]      fm_b,
   output logic [LEN-1:0]      fm_c,
   output logic [LEN-1:0]      fm_d,
   output logic                fm_vld,
   input  logic [3*LEN-1:0]    fm_res,
   input  logic                fm_ovf,
   input  logic                fm_out_vld,
   output logic [NREQ-1:0]     rsp_vld,
   output logic [3*LEN-1:0]    rsp_res,
   output logic                rsp_ovf,
   output logic                busy,
   output logic                tag_err
`ifdef FORMULA_SCHED_STATS_EN
   ,
   output logic [NREQ*16-1:0]  grant_cnt,
   output logic [15:0]         ovf_cnt
`endif
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(LAT + 1);
   localparam int          N  = int'(NREQ);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } state_e;

   state_e        state_q;
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] fm_idx_q;
   logic [LAT-1:0] tag_vld_q;
   logic [PW-1:0] tag_idx_q [LAT];
   logic [CW-1:0] cnt_q, cnt_d;
   // Suppresses error detection after reset. Results from the pipeline may still
   // arrive for up to LAT cycles, and they no longer have tags.
   logic [CW-1:0] blank_q;

   logic          gnt, acc;
   logic [PW-1:0] gnt_idx;
   int            idx;
   logic          last_vld;
   logic [PW-1:0] last_idx;
   logic          resp_ok, err_now;

   // Round-robin search: start at ptr and wrap upward.
   always_comb begin
      gnt     = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (!gnt && req_vld[PW'(idx)]) begin
            gnt     = 1'b1;
            gnt_idx = PW'(idx);
         end
      end
      acc     = gnt && en && !rst;
      req_rdy = '0;
      if (acc) req_rdy[gnt_idx] = 1'b1;
   end

   assign last_vld = tag_vld_q[LAT-1];
   assign last_idx = tag_idx_q[LAT-1];

   always_comb begin
      resp_ok = fm_out_vld && last_vld && (cnt_q != '0);
      err_now = (fm_out_vld && (!last_vld || (cnt_q == '0))) || (last_vld && !fm_out_vld);
      rsp_vld = '0;
      if (resp_ok) rsp_vld[last_idx] = 1'b1;
   end

   assign rsp_res = fm_res;
   assign rsp_ovf = fm_ovf;
   assign busy    = (cnt_q != '0) || fm_vld;

   // A simultaneous issue and return leaves the count unchanged.
   always_comb begin
      cnt_d = cnt_q;
      if (fm_vld && !fm_out_vld && (cnt_q != CW'(LAT))) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!fm_vld && fm_out_vld && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         fm_idx_q  <= '0;
         fm_vld    <= 1'b0;
         fm_a      <= '0;
         fm_b      <= '0;
         fm_c      <= '0;
         fm_d      <= '0;
         tag_vld_q <= '0;
         for (int s = 0; s < int'(LAT); s++) tag_idx_q[s] <= '0;
         cnt_q     <= '0;
         blank_q   <= CW'(LAT);
         tag_err   <= 1'b0;
      end else begin
         fm_vld <= acc;
         if (acc) begin
            ptr_q    <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
            fm_idx_q <= gnt_idx;
            fm_a     <= req_a[gnt_idx*LEN +: LEN];
            fm_b     <= req_b[gnt_idx*LEN +: LEN];
            fm_c     <= req_c[gnt_idx*LEN +: LEN];
            fm_d     <= req_d[gnt_idx*LEN +: LEN];
         end

         // Tags enter with fm_vld, so the last stage lines up with fm_out_vld.
         for (int s = int'(LAT) - 1; s > 0; s--) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_idx_q[s] <= tag_idx_q[s-1];
         end
         tag_vld_q[0] <= fm_vld;
         tag_idx_q[0] <= fm_idx_q;

         cnt_q <= cnt_d;

         if (fm_vld)               blank_q <= '0;
         else if (blank_q != '0)   blank_q <= blank_q - 1'b1;

         if (err_now && (blank_q == '0)) tag_err <= 1'b1;

         unique case (state_q)
            StIdle:  if (fm_vld) state_q <= StRun;
            StRun: begin
               if (cnt_d == '0)  state_q <= StIdle;
               else if (!en)     state_q <= StDrain;
            end
            StDrain: begin
               if (cnt_d == '0)  state_q <= StIdle;
               else if (en)      state_q <= StRun;
            end
            default:             state_q <= StIdle;
         endcase
      end
   end

`ifdef FORMULA_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt <= '0;
         ovf_cnt   <= '0;
      end else begin
         if (acc && (grant_cnt[gnt_idx*16 +: 16] != 16'hffff)) begin
            grant_cnt[gnt_idx*16 +: 16] <= grant_cnt[gnt_idx*16 +: 16] + 16'd1;
         end
         if (resp_ok && fm_ovf && (ovf_cnt != 16'hffff)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
